kb_scr_fifo_drv: RTL and testbench

Parametrised successor to the single-byte keyboard/screen driver. It adds a DEPTH-deep receive FIFO on the keyboard path and a DEPTH-deep transmit FIFO on the screen path, plus a CPU register port, per-channel interrupt requests, sticky overflow and a FIFO flush. It sits between the CPU memory-mapped device bus and the keyboard/screen device interfaces. The CSR bit layout is unchanged: 4 ena, 3 of, 2 dba, 1 io, 0 ie.

---
 rtl/kb_scr_fifo_drv.sv | 195 +++++++++++++++++++
 tb/tb_kb_scr_fifo_drv.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_scr_fifo_drv.sv
// Keyboard/screen driver with receive and transmit FIFOs behind a four-register CPU port.
// CSR layout per channel: 5 flush (W1, reads 0), 4 ena, 3 of (W1C), 2 dba, 1 io, 0 ie.
module kb_scr_fifo_drv #(
  parameter int DW        = 8,
  parameter int KB_DEPTH  = 8,
  parameter int SCR_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    reg_addr_i,
  input  logic          reg_wr_i,
  input  logic          reg_rd_i,
  input  logic [DW-1:0] reg_wdata_i,
  output logic [DW-1:0] reg_rdata_o,
  input  logic          kb_valid_i,
  input  logic [DW-1:0] kb_data_i,
  output logic          kb_ready_o,
  output logic          scr_valid_o,
  output logic [DW-1:0] scr_data_o,
  input  logic          scr_ready_i,
  output logic          irq_kb_o,
  output logic          irq_scr_o
);

  localparam int KB_AW  = $clog2(KB_DEPTH);
  localparam int KB_CW  = KB_AW + 1;
  localparam int SCR_AW = $clog2(SCR_DEPTH);
  localparam int SCR_CW = SCR_AW + 1;

  localparam logic [KB_CW-1:0]  KB_FULL_CNT  = KB_CW'(KB_DEPTH);
  localparam logic [SCR_CW-1:0] SCR_FULL_CNT = SCR_CW'(SCR_DEPTH);

  localparam logic [1:0] ADDR_KB_CSR  = 2'd0;
  localparam logic [1:0] ADDR_KB_DATA = 2'd1;
  localparam logic [1:0] ADDR_SCR_CSR = 2'd2;
  localparam logic [1:0] ADDR_SCR_DAT = 2'd3;

  localparam int BIT_IE    = 0;
  localparam int BIT_OF    = 3;
  localparam int BIT_ENA   = 4;
  localparam int BIT_FLUSH = 5;

  // Storage is intentionally left out of reset.
  logic [DW-1:0] kb_mem  [KB_DEPTH];
  logic [DW-1:0] scr_mem [SCR_DEPTH];

  logic [KB_AW-1:0]  kb_wr_ptr_reg,  kb_wr_ptr_next,  kb_rd_ptr_reg,  kb_rd_ptr_next;
  logic [KB_CW-1:0]  kb_cnt_reg,     kb_cnt_next;
  logic [SCR_AW-1:0] scr_wr_ptr_reg, scr_wr_ptr_next, scr_rd_ptr_reg, scr_rd_ptr_next;
  logic [SCR_CW-1:0] scr_cnt_reg,    scr_cnt_next;

  logic kb_ena_reg,  kb_ena_next,  kb_ie_reg,  kb_ie_next,  kb_of_reg,  kb_of_next;
  logic scr_ena_reg, scr_ena_next, scr_ie_reg, scr_ie_next, scr_of_reg, scr_of_next;
  logic [DW-1:0] reg_rdata_reg, reg_rdata_next;

  logic kb_empty, kb_full, scr_empty, scr_full;
  logic kb_dba, scr_dba;
  logic wr_kb_csr, wr_scr_csr, wr_scr_data, rd_kb_data;
  logic kb_flush, kb_push_req, kb_push, kb_pop, kb_ovf;
  logic scr_flush, scr_push_req, scr_push, scr_pop, scr_ovf;
  logic [7:0] kb_csr, scr_csr;

  assign kb_empty  = (kb_cnt_reg == '0);
  assign kb_full   = (kb_cnt_reg == KB_FULL_CNT);
  assign scr_empty = (scr_cnt_reg == '0);
  assign scr_full  = (scr_cnt_reg == SCR_FULL_CNT);
  assign kb_dba    = ~kb_empty;
  assign scr_dba   = ~scr_full;

  assign wr_kb_csr   = reg_wr_i & (reg_addr_i == ADDR_KB_CSR);
  assign wr_scr_csr  = reg_wr_i & (reg_addr_i == ADDR_SCR_CSR);
  assign wr_scr_data = reg_wr_i & (reg_addr_i == ADDR_SCR_DAT);
  assign rd_kb_data  = reg_rd_i & (reg_addr_i == ADDR_KB_DATA);

  assign kb_csr  = {3'b000, kb_ena_reg,  kb_of_reg,  kb_dba,  1'b0, kb_ie_reg};
  assign scr_csr = {3'b000, scr_ena_reg, scr_of_reg, scr_dba, 1'b1, scr_ie_reg};

  assign kb_ready_o  = kb_ena_reg;
  assign scr_valid_o = scr_ena_reg & ~scr_empty;
  assign scr_data_o  = scr_valid_o ? scr_mem[scr_rd_ptr_reg] : '0;
  assign irq_kb_o    = kb_ie_reg & (kb_dba | kb_of_reg);
  assign irq_scr_o   = scr_ie_reg & scr_ena_reg & (scr_dba | scr_of_reg);
  assign reg_rdata_o = reg_rdata_reg;

  // A push into a full FIFO survives only when a pop frees the slot in the same cycle.
  assign kb_flush    = wr_kb_csr & reg_wdata_i[BIT_FLUSH];
  assign kb_push_req = kb_valid_i & kb_ena_reg;
  assign kb_pop      = rd_kb_data & ~kb_empty;
  assign kb_push     = kb_push_req & (~kb_full | kb_pop) & ~kb_flush;
  assign kb_ovf      = kb_push_req & kb_full & ~kb_pop & ~kb_flush;

  assign scr_flush    = wr_scr_csr & reg_wdata_i[BIT_FLUSH];
  assign scr_push_req = wr_scr_data & scr_ena_reg;
  assign scr_pop      = scr_valid_o & scr_ready_i;
  assign scr_push     = scr_push_req & (~scr_full | scr_pop) & ~scr_flush;
  assign scr_ovf      = scr_push_req & scr_full & ~scr_pop & ~scr_flush;

  always_comb begin
    kb_ena_next  = kb_ena_reg;
    kb_ie_next   = kb_ie_reg;
    scr_ena_next = scr_ena_reg;
    scr_ie_next  = scr_ie_reg;
    if (wr_kb_csr) begin
      kb_ena_next = reg_wdata_i[BIT_ENA];
      kb_ie_next  = reg_wdata_i[BIT_IE];
    end
    if (wr_scr_csr) begin
      scr_ena_next = reg_wdata_i[BIT_ENA];
      scr_ie_next  = reg_wdata_i[BIT_IE];
    end
    kb_of_next  = (kb_of_reg  & ~(wr_kb_csr  & reg_wdata_i[BIT_OF])) | kb_ovf;
    scr_of_next = (scr_of_reg & ~(wr_scr_csr & reg_wdata_i[BIT_OF])) | scr_ovf;
  end

  always_comb begin
    kb_wr_ptr_next = kb_wr_ptr_reg;
    kb_rd_ptr_next = kb_rd_ptr_reg;
    kb_cnt_next    = kb_cnt_reg;
    if (kb_flush) begin
      kb_wr_ptr_next = '0;
      kb_rd_ptr_next = '0;
      kb_cnt_next    = '0;
    end else begin
      if (kb_push) kb_wr_ptr_next = kb_wr_ptr_reg + KB_AW'(1);
      if (kb_pop)  kb_rd_ptr_next = kb_rd_ptr_reg + KB_AW'(1);
      kb_cnt_next = kb_cnt_reg + KB_CW'(kb_push) - KB_CW'(kb_pop);
    end
  end

  always_comb begin
    scr_wr_ptr_next = scr_wr_ptr_reg;
    scr_rd_ptr_next = scr_rd_ptr_reg;
    scr_cnt_next    = scr_cnt_reg;
    if (scr_flush) begin
      scr_wr_ptr_next = '0;
      scr_rd_ptr_next = '0;
      scr_cnt_next    = '0;
    end else begin
      if (scr_push) scr_wr_ptr_next = scr_wr_ptr_reg + SCR_AW'(1);
      if (scr_pop)  scr_rd_ptr_next = scr_rd_ptr_reg + SCR_AW'(1);
      scr_cnt_next = scr_cnt_reg + SCR_CW'(scr_push) - SCR_CW'(scr_pop);
    end
  end

  // Reads sample pre-update state; the value holds until the next read strobe.
  always_comb begin
    reg_rdata_next = reg_rdata_reg;
    if (reg_rd_i) begin
      unique case (reg_addr_i)
        ADDR_KB_CSR:  reg_rdata_next = DW'(kb_csr);
        ADDR_KB_DATA: reg_rdata_next = kb_empty ? '0 : kb_mem[kb_rd_ptr_reg];
        ADDR_SCR_CSR: reg_rdata_next = DW'(scr_csr);
        default:      reg_rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_wr_ptr_reg  <= '0;
      kb_rd_ptr_reg  <= '0;
      kb_cnt_reg     <= '0;
      scr_wr_ptr_reg <= '0;
      scr_rd_ptr_reg <= '0;
      scr_cnt_reg    <= '0;
      kb_ena_reg     <= 1'b0;
      kb_ie_reg      <= 1'b0;
      kb_of_reg      <= 1'b0;
      scr_ena_reg    <= 1'b0;
      scr_ie_reg     <= 1'b0;
      scr_of_reg     <= 1'b0;
      reg_rdata_reg  <= '0;
    end else begin
      kb_wr_ptr_reg  <= kb_wr_ptr_next;
      kb_rd_ptr_reg  <= kb_rd_ptr_next;
      kb_cnt_reg     <= kb_cnt_next;
      scr_wr_ptr_reg <= scr_wr_ptr_next;
      scr_rd_ptr_reg <= scr_rd_ptr_next;
      scr_cnt_reg    <= scr_cnt_next;
      kb_ena_reg     <= kb_ena_next;
      kb_ie_reg      <= kb_ie_next;
      kb_of_reg      <= kb_of_next;
      scr_ena_reg    <= scr_ena_next;
      scr_ie_reg     <= scr_ie_next;
      scr_of_reg     <= scr_of_next;
      reg_rdata_reg  <= reg_rdata_next;
    end
  end

  always_ff @(posedge clk) begin
    if (kb_push)  kb_mem[kb_wr_ptr_reg]   <= kb_data_i;
    if (scr_push) scr_mem[scr_wr_ptr_reg] <= reg_wdata_i;
  end

endmodule

// File: tb/tb_kb_scr_fifo_drv.sv
// Randomised bench for kb_scr_fifo_drv against a queue-based model of both channels.
module tb_kb_scr_fifo_drv;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    reg_addr_i = '0;
  logic          reg_wr_i = 1'b0;
  logic          reg_rd_i = 1'b0;
  logic [DW-1:0] reg_wdata_i = '0;
  logic [DW-1:0] reg_rdata_o;
  logic          kb_valid_i = 1'b0;
  logic [DW-1:0] kb_data_i = '0;
  logic          kb_ready_o;
  logic          scr_valid_o;
  logic [DW-1:0] scr_data_o;
  logic          scr_ready_i = 1'b0;
  logic          irq_kb_o;
  logic          irq_scr_o;

  always #5 clk = ~clk;

  kb_scr_fifo_drv #(.DW(DW), .KB_DEPTH(DEPTH), .SCR_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_addr_i(reg_addr_i), .reg_wr_i(reg_wr_i), .reg_rd_i(reg_rd_i),
    .reg_wdata_i(reg_wdata_i), .reg_rdata_o(reg_rdata_o),
    .kb_valid_i(kb_valid_i), .kb_data_i(kb_data_i), .kb_ready_o(kb_ready_o),
    .scr_valid_o(scr_valid_o), .scr_data_o(scr_data_o), .scr_ready_i(scr_ready_i),
    .irq_kb_o(irq_kb_o), .irq_scr_o(irq_scr_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain queues plus the CSR flags.
  logic [7:0] kb_q[$];
  logic [7:0] scr_q[$];
  logic m_kb_ena, m_kb_ie, m_kb_of, m_scr_ena, m_scr_ie, m_scr_of;
  logic [7:0] m_rdata;

  function automatic logic [7:0] m_kb_csr();
    return {3'b000, m_kb_ena, m_kb_of, (kb_q.size() != 0), 1'b0, m_kb_ie};
  endfunction

  function automatic logic [7:0] m_scr_csr();
    return {3'b000, m_scr_ena, m_scr_of, (scr_q.size() != DEPTH), 1'b1, m_scr_ie};
  endfunction

  function automatic logic m_irq_kb();
    return m_kb_ie & ((kb_q.size() != 0) | m_kb_of);
  endfunction

  function automatic logic m_irq_scr();
    return m_scr_ie & m_scr_ena & ((scr_q.size() != DEPTH) | m_scr_of);
  endfunction

  function automatic logic m_scr_valid();
    return m_scr_ena & (scr_q.size() != 0);
  endfunction

  function automatic logic [7:0] m_scr_data();
    return m_scr_valid() ? scr_q[0] : 8'h00;
  endfunction

  task automatic m_reset();
    kb_q.delete();
    scr_q.delete();
    {m_kb_ena, m_kb_ie, m_kb_of, m_scr_ena, m_scr_ie, m_scr_of} = '0;
    m_rdata = 8'h00;
  endtask

  // Drive one clock of stimulus and advance the model by the same cycle.
  task automatic step(input bit rd, input bit wr, input logic [1:0] addr, input logic [7:0] wd,
                      input bit kv, input logic [7:0] kd, input bit srdy);
    int kn, sn;
    bit kpop, kflush, kpush, kovf, spop, sflush, spush, sovf;
    reg_rd_i = rd; reg_wr_i = wr; reg_addr_i = addr; reg_wdata_i = wd;
    kb_valid_i = kv; kb_data_i = kd; scr_ready_i = srdy;
    kn = kb_q.size();
    sn = scr_q.size();
    if (rd) begin
      case (addr)
        2'd0:    m_rdata = m_kb_csr();
        2'd1:    m_rdata = (kn != 0) ? kb_q[0] : 8'h00;
        2'd2:    m_rdata = m_scr_csr();
        default: m_rdata = 8'h00;
      endcase
    end
    kpop   = rd && addr == 2'd1 && kn != 0;
    kflush = wr && addr == 2'd0 && wd[5];
    kpush  = kv && m_kb_ena;
    kovf   = 1'b0;
    if (kflush) kb_q.delete();
    else begin
      if (kpop) void'(kb_q.pop_front());
      if (kpush) begin
        if (kn == DEPTH && !kpop) kovf = 1'b1;
        else kb_q.push_back(kd);
      end
    end
    spop   = m_scr_ena && sn != 0 && srdy;
    sflush = wr && addr == 2'd2 && wd[5];
    spush  = wr && addr == 2'd3 && m_scr_ena;
    sovf   = 1'b0;
    if (sflush) scr_q.delete();
    else begin
      if (spop) void'(scr_q.pop_front());
      if (spush) begin
        if (sn == DEPTH && !spop) sovf = 1'b1;
        else scr_q.push_back(wd);
      end
    end
    if (wr && addr == 2'd0) begin
      m_kb_of = m_kb_of & ~wd[3]; m_kb_ena = wd[4]; m_kb_ie = wd[0];
    end
    if (wr && addr == 2'd2) begin
      m_scr_of = m_scr_of & ~wd[3]; m_scr_ena = wd[4]; m_scr_ie = wd[0];
    end
    if (kovf) m_kb_of = 1'b1;
    if (sovf) m_scr_of = 1'b1;
    @(posedge clk); #1;
    reg_rd_i = 1'b0; reg_wr_i = 1'b0; kb_valid_i = 1'b0; scr_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (reg_rdata_o !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", reg_rdata_o); end
    checks++; if ({kb_ready_o, scr_valid_o, irq_kb_o, irq_scr_o} !== 4'b0000) begin errors++; $display("FAIL reset_outs got=%b exp=0000", {kb_ready_o, scr_valid_o, irq_kb_o, irq_scr_o}); end
    checks++; if (scr_data_o !== 8'h00) begin errors++; $display("FAIL reset_scr_data got=%h exp=00", scr_data_o); end
    step(1, 0, 2'd0, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h00) begin errors++; $display("FAIL reset_kb_csr got=%h exp=00", reg_rdata_o); end
    step(1, 0, 2'd2, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h06) begin errors++; $display("FAIL reset_scr_csr got=%h exp=06", reg_rdata_o); end
    $display("test_reset done");
  endtask

  task automatic test_kb_basic();
    step(0, 1, 2'd0, 8'h11, 0, 8'h00, 0);
    checks++; if (kb_ready_o !== 1'b1) begin errors++; $display("FAIL kb_ready got=%b exp=1", kb_ready_o); end
    step(0, 0, 2'd0, 8'h00, 1, 8'h41, 0);
    step(0, 0, 2'd0, 8'h00, 1, 8'h42, 0);
    step(1, 0, 2'd0, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h15) begin errors++; $display("FAIL kb_csr_dba got=%h exp=15", reg_rdata_o); end
    checks++; if (irq_kb_o !== 1'b1) begin errors++; $display("FAIL kb_irq_on got=%b exp=1", irq_kb_o); end
    step(1, 0, 2'd1, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h41) begin errors++; $display("FAIL kb_read0 got=%h exp=41", reg_rdata_o); end
    step(1, 0, 2'd1, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h42) begin errors++; $display("FAIL kb_read1 got=%h exp=42", reg_rdata_o); end
    step(1, 0, 2'd0, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h11) begin errors++; $display("FAIL kb_csr_empty got=%h exp=11", reg_rdata_o); end
    checks++; if (irq_kb_o !== 1'b0) begin errors++; $display("FAIL kb_irq_off got=%b exp=0", irq_kb_o); end
    step(1, 0, 2'd1, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h00) begin errors++; $display("FAIL kb_read_empty got=%h exp=00", reg_rdata_o); end
    $display("test_kb_basic done");
  endtask

  task automatic test_kb_overflow();
    logic [7:0] pushed[DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      pushed[i] = 8'($urandom_range(1, 255));
      step(0, 0, 2'd0, 8'h00, 1, pushed[i], 0);
    end
    step(0, 0, 2'd0, 8'h00, 1, 8'h99, 0);
    step(1, 0, 2'd0, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h1D) begin errors++; $display("FAIL kb_of_csr got=%h exp=1d", reg_rdata_o); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 2'd1, 8'h00, 0, 8'h00, 0);
      checks++; if (reg_rdata_o !== pushed[i]) begin errors++; $display("FAIL kb_of_read%0d got=%h exp=%h", i, reg_rdata_o, pushed[i]); end
    end
    step(0, 1, 2'd0, 8'h08, 0, 8'h00, 0);
    step(1, 0, 2'd0, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h00) begin errors++; $display("FAIL kb_of_clear got=%h exp=00", reg_rdata_o); end
    step(0, 1, 2'd0, 8'h11, 0, 8'h00, 0);
    $display("test_kb_overflow done");
  endtask

  task automatic test_kb_full_push_pop();
    for (int i = 0; i < DEPTH; i++) step(0, 0, 2'd0, 8'h00, 1, 8'(8'h60 + i), 0);
    step(1, 0, 2'd1, 8'h00, 1, 8'h55, 0);
    checks++; if (reg_rdata_o !== 8'h60) begin errors++; $display("FAIL kb_pp_first got=%h exp=60", reg_rdata_o); end
    step(1, 0, 2'd0, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h15) begin errors++; $display("FAIL kb_pp_csr got=%h exp=15", reg_rdata_o); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 2'd1, 8'h00, 0, 8'h00, 0);
      checks++; if (reg_rdata_o !== m_rdata) begin errors++; $display("FAIL kb_pp_read%0d got=%h exp=%h", i, reg_rdata_o, m_rdata); end
    end
    checks++; if (reg_rdata_o !== 8'h55) begin errors++; $display("FAIL kb_pp_last got=%h exp=55", reg_rdata_o); end
    $display("test_kb_full_push_pop done");
  endtask

  task automatic test_scr_fill_drain();
    step(0, 1, 2'd2, 8'h10, 0, 8'h00, 0);
    for (int i = 0; i <= DEPTH; i++) step(0, 1, 2'd3, 8'($urandom_range(1, 255)), 0, 8'h00, 0);
    step(1, 0, 2'd2, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h1A) begin errors++; $display("FAIL scr_full_csr got=%h exp=1a", reg_rdata_o); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (scr_valid_o !== 1'b1 || scr_data_o !== m_scr_data()) begin errors++; $display("FAIL scr_drain%0d got=%b/%h exp=1/%h", i, scr_valid_o, scr_data_o, m_scr_data()); end
      step(0, 0, 2'd0, 8'h00, 0, 8'h00, 1);
    end
    checks++; if (scr_valid_o !== 1'b0) begin errors++; $display("FAIL scr_drained_valid got=%b exp=0", scr_valid_o); end
    step(1, 0, 2'd2, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h1E) begin errors++; $display("FAIL scr_drained_csr got=%h exp=1e", reg_rdata_o); end
    step(0, 1, 2'd2, 8'h18, 0, 8'h00, 0);
    $display("test_scr_fill_drain done");
  endtask

  task automatic test_scr_flush();
    for (int i = 0; i < 3; i++) step(0, 1, 2'd3, 8'(8'hA0 + i), 0, 8'h00, 0);
    checks++; if (scr_valid_o !== 1'b1 || scr_data_o !== 8'hA0) begin errors++; $display("FAIL scr_pre_flush got=%b/%h exp=1/a0", scr_valid_o, scr_data_o); end
    step(0, 1, 2'd2, 8'h30, 0, 8'h00, 0);
    checks++; if (scr_valid_o !== 1'b0 || scr_data_o !== 8'h00) begin errors++; $display("FAIL scr_flush_valid got=%b/%h exp=0/00", scr_valid_o, scr_data_o); end
    step(0, 0, 2'd0, 8'h00, 0, 8'h00, 1);
    checks++; if (scr_valid_o !== 1'b0) begin errors++; $display("FAIL scr_flush_emit got=%b exp=0", scr_valid_o); end
    step(1, 0, 2'd2, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h16) begin errors++; $display("FAIL scr_flush_csr got=%h exp=16", reg_rdata_o); end
    $display("test_scr_flush done");
  endtask

  task automatic test_random();
    int r;
    bit rd, wr, kv, srdy;
    logic [1:0] addr;
    logic [7:0] wd;
    step(0, 1, 2'd0, 8'h11, 0, 8'h00, 0);
    step(0, 1, 2'd2, 8'h11, 0, 8'h00, 0);
    for (int c = 0; c < 500; c++) begin
      r = $urandom_range(0, 99);
      rd = 0; wr = 0; addr = 2'($urandom_range(0, 3)); wd = 8'($urandom_range(0, 255));
      if (r < 20) rd = 1;
      else if (r < 50) begin wr = 1; addr = 2'd3; end
      else if (r < 58) begin
        wr = 1; addr = (r < 54) ? 2'd0 : 2'd2;
        wd = {2'b00, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0),
              1'($urandom_range(0, 1)), 2'b00, 1'($urandom_range(0, 1))};
      end
      kv   = 1'($urandom_range(0, 1));
      srdy = ($urandom_range(0, 3) == 0);
      checks++; if (kb_ready_o !== m_kb_ena) begin errors++; $display("FAIL rnd_kb_ready cyc=%0d got=%b exp=%b", c, kb_ready_o, m_kb_ena); end
      checks++; if (scr_valid_o !== m_scr_valid()) begin errors++; $display("FAIL rnd_scr_valid cyc=%0d got=%b exp=%b", c, scr_valid_o, m_scr_valid()); end
      checks++; if (scr_data_o !== m_scr_data()) begin errors++; $display("FAIL rnd_scr_data cyc=%0d got=%h exp=%h", c, scr_data_o, m_scr_data()); end
      checks++; if (irq_kb_o !== m_irq_kb()) begin errors++; $display("FAIL rnd_irq_kb cyc=%0d got=%b exp=%b", c, irq_kb_o, m_irq_kb()); end
      checks++; if (irq_scr_o !== m_irq_scr()) begin errors++; $display("FAIL rnd_irq_scr cyc=%0d got=%b exp=%b", c, irq_scr_o, m_irq_scr()); end
      step(rd, wr, addr, wd, kv, 8'($urandom_range(0, 255)), srdy);
      checks++; if (reg_rdata_o !== m_rdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d addr=%0d got=%h exp=%h", c, addr, reg_rdata_o, m_rdata); end
    end
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    step(0, 1, 2'd0, 8'h11, 0, 8'h00, 0);
    step(0, 1, 2'd2, 8'h11, 0, 8'h00, 0);
    step(0, 1, 2'd0, 8'h31, 0, 8'h00, 0);
    step(0, 1, 2'd2, 8'h39, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 2'd3, 8'(8'hC0 + i), 1, 8'(8'h70 + i), 0);
    step(1, 0, 2'd1, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h70) begin errors++; $display("FAIL arst_pre_read got=%h exp=70", reg_rdata_o); end
    kb_valid_i = 1'b1; kb_data_i = 8'h77; scr_ready_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    checks++; if (reg_rdata_o !== 8'h00 || scr_data_o !== 8'h00) begin errors++; $display("FAIL arst_data got=%h/%h exp=00/00", reg_rdata_o, scr_data_o); end
    checks++; if ({kb_ready_o, scr_valid_o, irq_kb_o, irq_scr_o} !== 4'b0000) begin errors++; $display("FAIL arst_outs got=%b exp=0000", {kb_ready_o, scr_valid_o, irq_kb_o, irq_scr_o}); end
    kb_valid_i = 1'b0; scr_ready_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 0, 2'd1, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h00) begin errors++; $display("FAIL arst_kb_read got=%h exp=00", reg_rdata_o); end
    step(1, 0, 2'd2, 8'h00, 0, 8'h00, 0);
    checks++; if (reg_rdata_o !== 8'h06) begin errors++; $display("FAIL arst_scr_csr got=%h exp=06", reg_rdata_o); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_kb_basic();
    test_kb_overflow();
    test_kb_full_push_pop();
    test_scr_fill_drain();
    test_scr_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
